// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encodings,
// next-PC select codes, NOP encoding, MIPS-style opcode values and the default
// reset PC. Optional stall counter in if_stage is enabled by IF_STALL_COUNT_EN.
package if_stage_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] PC_STEP          = 32'd4;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } fsm_state_e;

   typedef enum logic [1:0] {
      PC_HOLD  = 2'd0,
      PC_ADV   = 2'd1,
      PC_REDIR = 2'd2
   } pc_sel_e;

   typedef enum logic [5:0] {
      OP_RTYPE = 6'h00,
      OP_J     = 6'h02,
      OP_JAL   = 6'h03,
      OP_BEQ   = 6'h04,
      OP_BNE   = 6'h05,
      OP_ADDI  = 6'h08,
      OP_LW    = 6'h23,
      OP_SW    = 6'h2B
   } opcode_e;

   // Instruction addresses are word aligned; low two bits are dropped.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter register with next-PC mux and +4 adder. The select input
// chooses between holding, sequential advance and a word-aligned redirect.
module pc_reg
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        reset_n,
   input  pc_sel_e     sel_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] pc_o,
   output logic [31:0] pc4_o
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] pc4;

   // Sequential address; 32-bit add wraps FFFF_FFFC to 0 naturally.
   assign pc4 = pc_q + PC_STEP;

   // Next-PC selection.
   always_comb begin
      pc_d = pc_q;
      case (sel_i)
         PC_ADV:   pc_d = pc4;
         PC_REDIR: pc_d = align_word(redirect_pc_i);
         default:  pc_d = pc_q;
      endcase
   end

   // PC register, asynchronously forced to the reset vector.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o  = pc_q;
   assign pc4_o = pc4;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: BOOT/RUN/HOLD control, IF/ID pipeline latch and
// decoded register fields for the hazard unit.
// Handshake: imem is a combinational read (imem_rdata valid in the same cycle
// as imem_addr); stall holds PC and IF/ID; redirect_valid wins over stall and
// inserts a bubble; both are ignored during BOOT.
// Optional: define IF_STALL_COUNT_EN to add the saturating stall_count output.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc4,
   output logic [31:0] if_id_instr,
   output logic [5:0]  if_id_opcode,
   output logic [4:0]  if_id_rs,
   output logic [4:0]  if_id_rt,
`ifdef IF_STALL_COUNT_EN
   output logic [31:0] stall_count,
`endif
   output fsm_state_e  state_dbg_o
);

   fsm_state_e  state_q;
   logic        valid_q;
   logic [31:0] if_pc_q;
   logic [31:0] if_pc4_q;
   logic [31:0] instr_q;
   pc_sel_e     pc_sel;
   logic [31:0] pc;
   logic [31:0] pc4;

   // Per-cycle priority outside BOOT: redirect, then stall, then advance.
   always_comb begin
      pc_sel = PC_HOLD;
      if (state_q != ST_BOOT) begin
         if (redirect_valid) begin
            pc_sel = PC_REDIR;
         end else if (stall) begin
            pc_sel = PC_HOLD;
         end else begin
            pc_sel = PC_ADV;
         end
      end
   end

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk           (clk),
      .reset_n       (reset_n),
      .sel_i         (pc_sel),
      .redirect_pc_i (redirect_pc),
      .pc_o          (pc),
      .pc4_o         (pc4)
   );

   // FSM and IF/ID latch; BOOT only waits one cycle and latches nothing.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_BOOT;
         valid_q  <= 1'b0;
         if_pc_q  <= 32'h0;
         if_pc4_q <= 32'h0;
         instr_q  <= NOP_INSTR;
      end else begin
         case (state_q)
            ST_BOOT: begin
               state_q <= ST_RUN;
            end
            default: begin
               if (redirect_valid) begin
                  state_q  <= ST_RUN;
                  valid_q  <= 1'b0;
                  if_pc_q  <= 32'h0;
                  if_pc4_q <= 32'h0;
                  instr_q  <= NOP_INSTR;
               end else if (stall) begin
                  state_q <= ST_HOLD;
               end else begin
                  state_q  <= ST_RUN;
                  valid_q  <= 1'b1;
                  if_pc_q  <= pc;
                  if_pc4_q <= pc4;
                  instr_q  <= imem_rdata;
               end
            end
         endcase
      end
   end

`ifdef IF_STALL_COUNT_EN
   logic [31:0] stall_cnt_q;

   // Count cycles that cause HOLD; saturate at all-ones.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= 32'h0;
      end else if ((state_q != ST_BOOT) && stall && !redirect_valid &&
                   (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_count = stall_cnt_q;
`endif

   assign imem_addr    = pc;
   assign if_id_valid  = valid_q;
   assign if_id_pc     = if_pc_q;
   assign if_id_pc4    = if_pc4_q;
   assign if_id_instr  = instr_q;
   assign if_id_opcode = valid_q ? instr_q[31:26] : 6'h0;
   assign if_id_rs     = valid_q ? instr_q[25:21] : 5'h0;
   assign if_id_rt     = valid_q ? instr_q[20:16] : 5'h0;
   assign state_dbg_o  = state_q;

endmodule
